// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA image path.
package vga_pkg;

  typedef logic [11:0] pixel_t;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 240;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of RGB444 pixels: synchronous write, asynchronous read at the same address,
// so a read in the write cycle returns the old contents.
module line_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH  = IMG_WIDTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  pixel_t            i_wdata,
  output pixel_t            o_rdata
);

  pixel_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting only interior windows with the centre coordinate, one cycle after the newest pixel.
module window_3x3_gen
  import vga_pkg::*;
#(
  parameter  int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter  int IMG_HEIGHT = IMG_HEIGHT_DEF,
  localparam int XW         = $clog2(IMG_WIDTH),
  localparam int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   pixel_i,
  input  logic          valid_i,
  input  logic          sof_i,
  output logic [11:0]   data_00_o,
  output logic [11:0]   data_01_o,
  output logic [11:0]   data_02_o,
  output logic [11:0]   data_10_o,
  output logic [11:0]   data_11_o,
  output logic [11:0]   data_12_o,
  output logic [11:0]   data_20_o,
  output logic [11:0]   data_21_o,
  output logic [11:0]   data_22_o,
  output logic          valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_done_o
);

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] COL_INT  = XW'(2);
  localparam logic [YW-1:0] ROW_INT  = YW'(2);

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic [XW-1:0] w_col;
  logic [YW-1:0] w_row;
  logic [XW-1:0] w_col_nxt;
  logic [YW-1:0] w_row_nxt;
  logic          w_we;
  logic          w_interior;
  logic          w_last;
  pixel_t        w_lb0_rd;
  pixel_t        w_lb1_rd;

  pixel_t        r_win_p1 [3][3];
  logic          r_vld_p1;
  logic          r_fd_p1;
  logic [XW-1:0] r_x_p1;
  logic [YW-1:0] r_y_p1;

  // sof forces the accepted pixel to (0,0) regardless of where the counters were
  always_comb begin
    w_col      = (valid_i && sof_i) ? '0 : r_col;
    w_row      = (valid_i && sof_i) ? '0 : r_row;
    w_we       = valid_i && !reset;
    w_interior = (w_row >= ROW_INT) && (w_col >= COL_INT);
    w_last     = (w_row == ROW_LAST) && (w_col == COL_LAST);
    w_col_nxt  = w_col + XW'(1);
    w_row_nxt  = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + YW'(1);
    end
  end

  // lb0 holds row r-1 and feeds lb1, which then holds row r-2
  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(XW)) u_lb0 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_col),
    .i_wdata (pixel_i),
    .o_rdata (w_lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(XW)) u_lb1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  // Stage p1: window shift, position tags and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_vld_p1 <= 1'b0;
      r_fd_p1  <= 1'b0;
      r_x_p1   <= '0;
      r_y_p1   <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win_p1[r][c] <= '0;
        end
      end
    end else begin
      r_vld_p1 <= valid_i && w_interior;
      r_fd_p1  <= valid_i && w_last;
      if (valid_i) begin
        r_col  <= w_col_nxt;
        r_row  <= w_row_nxt;
        r_x_p1 <= w_col - XW'(1);
        r_y_p1 <= w_row - YW'(1);
        for (int r = 0; r < 3; r++) begin
          r_win_p1[r][0] <= r_win_p1[r][1];
          r_win_p1[r][1] <= r_win_p1[r][2];
        end
        r_win_p1[0][2] <= w_lb1_rd;
        r_win_p1[1][2] <= w_lb0_rd;
        r_win_p1[2][2] <= pixel_i;
      end
    end
  end

  assign data_00_o    = r_win_p1[0][0];
  assign data_01_o    = r_win_p1[0][1];
  assign data_02_o    = r_win_p1[0][2];
  assign data_10_o    = r_win_p1[1][0];
  assign data_11_o    = r_win_p1[1][1];
  assign data_12_o    = r_win_p1[1][2];
  assign data_20_o    = r_win_p1[2][0];
  assign data_21_o    = r_win_p1[2][1];
  assign data_22_o    = r_win_p1[2][2];
  assign valid_o      = r_vld_p1;
  assign frame_done_o = r_fd_p1;
  assign x_o          = r_x_p1;
  assign y_o          = r_y_p1;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image, checked against an image-array reference model.
module tb_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        sof_i;
  logic [11:0] pixel_i;
  logic [11:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic        valid_o;
  logic        frame_done_o;
  logic [1:0]  x_o;
  logic [1:0]  y_o;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .pixel_i(pixel_i), .valid_i(valid_i), .sof_i(sof_i),
    .data_00_o(d00), .data_01_o(d01), .data_02_o(d02),
    .data_10_o(d10), .data_11_o(d11), .data_12_o(d12),
    .data_20_o(d20), .data_21_o(d21), .data_22_o(d22),
    .valid_o(valid_o), .x_o(x_o), .y_o(y_o), .frame_done_o(frame_done_o)
  );

  logic [11:0] obs [3][3];
  assign obs[0][0] = d00; assign obs[0][1] = d01; assign obs[0][2] = d02;
  assign obs[1][0] = d10; assign obs[1][1] = d11; assign obs[1][2] = d12;
  assign obs[2][0] = d20; assign obs[2][1] = d21; assign obs[2][2] = d22;

  int errors = 0;
  int checks = 0;

  // Reference model: position of next pixel, the image as accepted, and expected outputs
  int          m_col = 0;
  int          m_row = 0;
  logic [11:0] m_img [H][W];
  logic        e_valid = 1'b0;
  logic        e_fd = 1'b0;
  int          e_x = 0;
  int          e_y = 0;
  logic [11:0] e_win [3][3];
  bit          e_known = 1'b0;

  function automatic logic [11:0] pix(input int f, input int r, input int c);
    return {4'(f), 4'(r), 4'(c)};
  endfunction

  function automatic bit win_bad();
    bit bad = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (obs[r][c] !== e_win[r][c]) bad = 1'b1;
    return bad;
  endfunction

  task automatic beat(input logic v, input logic s, input logic rst, input logic [11:0] p);
    valid_i = v; sof_i = s; reset = rst; pixel_i = p;
    if (rst) begin
      m_col = 0; m_row = 0; e_valid = 0; e_fd = 0; e_x = 0; e_y = 0; e_known = 1;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) e_win[r][c] = '0;
    end else if (v) begin
      if (s) begin m_col = 0; m_row = 0; end
      m_img[m_row][m_col] = p;
      e_valid = (m_row >= 2) && (m_col >= 2);
      e_fd    = (m_row == H-1) && (m_col == W-1);
      e_x     = (m_col + W - 1) % W;
      e_y     = (m_row + H - 1) % H;
      e_known = e_valid;
      if (e_valid)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e_win[r][c] = m_img[m_row-2+r][m_col-2+c];
      m_col++;
      if (m_col == W) begin m_col = 0; m_row = (m_row + 1) % H; end
    end else begin
      e_valid = 0; e_fd = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      beat((i < 2) ? 1'($urandom) : 1'b0, 1'($urandom), (i < 2), 12'($urandom));
      checks++;
      if (valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
        errors++; $display("FAIL reset_pulses cycle %0d: valid_o=%b frame_done_o=%b, want 0 0", i, valid_o, frame_done_o);
      end
      checks++;
      if (x_o !== 2'd0 || y_o !== 2'd0 || win_bad()) begin
        errors++; $display("FAIL reset_outputs cycle %0d: x=%0d y=%0d d00=%h d11=%h d22=%h, want all 0", i, x_o, y_o, d00, d11, d22);
      end
    end
  endtask

  task automatic test_continuous();
    int nv = 0;
    for (int i = 0; i < W*H; i++) begin
      beat(1'b1, i == 0, 1'b0, pix(0, i / W, i % W));
      if (valid_o === 1'b1) nv++;
      checks++;
      if (valid_o !== e_valid || frame_done_o !== e_fd) begin
        errors++; $display("FAIL cont_pulses beat %0d: valid_o=%b fd=%b, want %b %b", i, valid_o, frame_done_o, e_valid, e_fd);
      end
      if (e_valid) begin
        checks++;
        if (win_bad() || x_o !== 2'(e_x) || y_o !== 2'(e_y)) begin
          errors++; $display("FAIL cont_window beat %0d: d00=%h d11=%h d22=%h x=%0d y=%0d, want %h %h %h %0d %0d",
                             i, d00, d11, d22, x_o, y_o, e_win[0][0], e_win[1][1], e_win[2][2], e_x, e_y);
        end
      end
      if (i == 10) begin
        checks++;
        if (valid_o !== 1'b1 || d00 !== 12'h000 || d11 !== 12'h011 || d22 !== 12'h022 || x_o !== 2'd1 || y_o !== 2'd1) begin
          errors++; $display("FAIL cont_first_window: v=%b d00=%h d11=%h d22=%h x=%0d y=%0d, want 1 000 011 022 1 1", valid_o, d00, d11, d22, x_o, y_o);
        end
      end
      if (i == W*H-1) begin
        checks++;
        if (frame_done_o !== 1'b1 || d22 !== 12'h033 || x_o !== 2'd2 || y_o !== 2'd2) begin
          errors++; $display("FAIL cont_last_window: fd=%b d22=%h x=%0d y=%0d, want 1 033 2 2", frame_done_o, d22, x_o, y_o);
        end
      end
    end
    checks++;
    if (nv != 4) begin errors++; $display("FAIL cont_count: valid_o pulses=%0d, want 4", nv); end
    beat(1'b0, 1'b1, 1'b0, 12'hfff);
    checks++;
    if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || d22 !== 12'h033 || x_o !== 2'd2) begin
      errors++; $display("FAIL cont_idle_hold: v=%b fd=%b d22=%h x=%0d, want 0 0 033 2", valid_o, frame_done_o, d22, x_o);
    end
  endtask

  task automatic test_gaps();
    int k = 0;
    int cyc = 0;
    int nv = 0;
    logic v;
    while (k < W*H && cyc < 200) begin
      v = 1'($urandom);
      beat(v, v ? (k == 0) : 1'($urandom), 1'b0, v ? pix(0, k / W, k % W) : 12'($urandom));
      if (v) k++;
      cyc++;
      if (valid_o === 1'b1) nv++;
      checks++;
      if (valid_o !== e_valid || frame_done_o !== e_fd || x_o !== 2'(e_x) || y_o !== 2'(e_y)) begin
        errors++; $display("FAIL gap_ctrl cycle %0d: v=%b fd=%b x=%0d y=%0d, want %b %b %0d %0d",
                           cyc, valid_o, frame_done_o, x_o, y_o, e_valid, e_fd, e_x, e_y);
      end
      if (e_known) begin
        checks++;
        if (win_bad()) begin
          errors++; $display("FAIL gap_window cycle %0d: d00=%h d11=%h d22=%h, want %h %h %h", cyc, d00, d11, d22, e_win[0][0], e_win[1][1], e_win[2][2]);
        end
      end
    end
    checks++;
    if (k < W*H) begin errors++; $display("FAIL gap_timeout: accepted=%0d, want %0d", k, W*H); end
    checks++;
    if (nv != 4) begin errors++; $display("FAIL gap_count: valid_o pulses=%0d, want 4", nv); end
  endtask

  task automatic test_sof_restart();
    int nv = 0;
    for (int i = 0; i < 6; i++) beat(1'b1, i == 0, 1'b0, pix(0, i / W, i % W));
    for (int i = 0; i < W*H; i++) begin
      beat(1'b1, i == 0, 1'b0, pix(2, i / W, i % W));
      if (valid_o === 1'b1) nv++;
      checks++;
      if (valid_o !== e_valid || frame_done_o !== e_fd) begin
        errors++; $display("FAIL sof_pulses beat %0d: v=%b fd=%b, want %b %b", i, valid_o, frame_done_o, e_valid, e_fd);
      end
      if (e_valid) begin
        checks++;
        if (win_bad() || d00[11:8] !== 4'h2 || d02[11:8] !== 4'h2) begin
          errors++; $display("FAIL sof_window beat %0d: d00=%h d02=%h d22=%h, want %h %h %h", i, d00, d02, d22, e_win[0][0], e_win[0][2], e_win[2][2]);
        end
      end
      if (i == 10) begin
        checks++;
        if (nv != 1) begin errors++; $display("FAIL sof_first_valid: pulses by new (2,2)=%0d, want 1", nv); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv [2] = '{0, 0};
    int nf [2] = '{0, 0};
    for (int i = 0; i < 2*W*H; i++) begin
      int f = i / (W*H);
      int p = i % (W*H);
      beat(1'b1, i == 0, 1'b0, pix(f, p / W, p % W));
      if (valid_o === 1'b1) nv[f]++;
      if (frame_done_o === 1'b1) nf[f]++;
      checks++;
      if (valid_o !== e_valid || frame_done_o !== e_fd) begin
        errors++; $display("FAIL b2b_pulses beat %0d: v=%b fd=%b, want %b %b", i, valid_o, frame_done_o, e_valid, e_fd);
      end
      if (e_valid) begin
        checks++;
        if (win_bad() || d00[11:8] !== 4'(f) || d11[11:8] !== 4'(f)) begin
          errors++; $display("FAIL b2b_window beat %0d: d00=%h d11=%h d22=%h, want %h %h %h", i, d00, d11, d22, e_win[0][0], e_win[1][1], e_win[2][2]);
        end
      end
    end
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (nv[f] != 4 || nf[f] != 1) begin
        errors++; $display("FAIL b2b_count frame %0d: valid=%0d done=%0d, want 4 1", f, nv[f], nf[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    for (int i = 0; i < 11; i++) beat(1'b1, i == 0, 1'b0, pix(0, i / W, i % W));
    beat(1'b1, 1'b0, 1'b1, pix(0, 2, 3));
    checks++;
    if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || x_o !== 2'd0 || y_o !== 2'd0 || win_bad()) begin
      errors++; $display("FAIL rstmid_outputs: v=%b x=%0d y=%0d d22=%h, want 0 0 0 000", valid_o, x_o, y_o, d22);
    end
    for (int n = 1; n <= W*H; n++) begin
      int p = n - 1;
      beat(1'b1, 1'b0, 1'b0, pix(3, p / W, p % W));
      if (valid_o === 1'b1 && first < 0) first = n;
      checks++;
      if (valid_o !== e_valid || (e_valid && win_bad())) begin
        errors++; $display("FAIL rstmid_beat %0d: v=%b d22=%h, want %b %h", n, valid_o, d22, e_valid, e_win[2][2]);
      end
    end
    checks++;
    if (first != 11) begin errors++; $display("FAIL rstmid_first: first valid after %0d beats, want 11", first); end
  endtask

  initial begin
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) m_img[r][c] = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_restart();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3×3 neighbourhood generator for the VGA image path. Takes one RGB444 pixel per accepted beat in raster order and buffers the two previous lines. Presents the full 3×3 window on nine 12-bit outputs, `data_00_o`…`data_22_o`, which drive the `data_*_i` inputs of the grayscale/kernel filter stage directly downstream. Only interior windows are emitted; no border padding.

## Interface
Parameters:
- `IMG_WIDTH`, 320, pixels per line (≥3)
- `IMG_HEIGHT`, 240, lines per frame (≥3)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pixel_i`  in  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}
- `valid_i`  in  1  pixel accepted this cycle; no backpressure
- `sof_i`  in  1  start of frame, qualified by `valid_i`; marks pixel (0,0)
- `data_00_o`…`data_22_o`  out  12 each  window; `data_RC_o`, R=row (0 top), C=col (0 left); `data_22_o` = newest pixel
- `valid_o`  out  1  window valid, one-cycle pulse per accepted interior pixel
- `x_o`  out  $clog2(IMG_WIDTH)  column of window centre
- `y_o`  out  $clog2(IMG_HEIGHT)  row of window centre
- `frame_done_o`  out  1  pulse coincident with the last `valid_o` of a frame

## Operation
- Counters `col`, `row` give the position of the pixel being accepted.
  - On `valid_i`: `col` increments. At `IMG_WIDTH-1` it wraps to 0 and `row` increments. `row` wraps from `IMG_HEIGHT-1` to 0.
  - `valid_i && sof_i`: the current pixel is taken as (0,0), whatever the counter state. Next position is (0,1).
- Two line buffers, each `IMG_WIDTH` × 12: `lb0` holds row r-1, `lb1` holds row r-2.
  - Asynchronous read at address `col`; read-before-write in the same cycle.
  - On accept: `lb1[col] <= lb0[col]`, `lb0[col] <= pixel_i`.
- Window shift on accept, for each row R: `data_R0 <= data_R1`, `data_R1 <= data_R2`.
  - New column: `data_02 <= lb1[col]`, `data_12 <= lb0[col]`, `data_22 <= pixel_i`.
- `valid_o <= valid_i && row>=2 && col>=2`, using the position of the accepted pixel.
- Centre coordinates: `x_o <= col-1`, `y_o <= row-1`, updated on every accept.
- `frame_done_o <= valid_i && row==IMG_HEIGHT-1 && col==IMG_WIDTH-1`.
- Windows are never emitted for rows 0-1 or cols 0-1. Stale line-buffer or window contents (previous line or frame) are therefore never marked valid.
- When `valid_i` is low, all state holds, and `valid_o` and `frame_done_o` go low.

## Timing
- Latency is 1 cycle: pixel accepted at edge N gives window outputs, `valid_o`, `x_o`/`y_o` and `frame_done_o` after edge N+1.
- Outputs are registered and change only on accepted beats. Between beats they hold, except the two pulse outputs, which return to 0.
- Reset: `col`=`row`=0; all `data_*_o`=0, `valid_o`=0, `x_o`=`y_o`=0, `frame_done_o`=0. Line-buffer RAM is not reset.
- Reset mid-frame: outputs are 0 in the cycle after reset. The first pixel after reset is treated as (0,0) even without `sof_i`.
- `reset` and `valid_i` together: reset wins and the pixel is dropped.
- Back-to-back frames: the row wrap gives no interior windows until row 2 of the new frame. Frame N+1 windows contain only frame N+1 pixels.

## Structure
- Shared package `vga_pkg`:
  - `typedef logic [11:0] pixel_t`
  - `IMG_WIDTH_DEF=320`, `IMG_HEIGHT_DEF=240`
- Sub-module `line_buffer` (parameter DEPTH; write enable, address, write data, async read data). Instantiated twice.
- Counters, window registers and the valid/coordinate logic stay in the top module.

## Test plan
All scenarios use `IMG_WIDTH=4`, `IMG_HEIGHT=4`, and stimulus pixel = 12'h0RC, where R is the row and C the column.
- Reset: hold `reset` 2 cycles with random inputs → all outputs 0; `valid_o` never high.
- Continuous frame (`sof_i` on the first beat):
  - First `valid_o` comes 1 cycle after pixel (2,2), with `data_00_o`=12'h000, `data_11_o`=12'h011, `data_22_o`=12'h022, `x_o`=1, `y_o`=1.
  - Exactly 4 `valid_o` pulses in the frame; `frame_done_o` coincides with the (3,3) window (`data_22_o`=12'h033, `x_o`=2, `y_o`=2).
- Random `valid_i` gaps (≈50% duty) → identical window sequence to the continuous case; `valid_o` always exactly 1 cycle after an accepted interior pixel; outputs hold across gaps.
- `sof_i` asserted at pixel (1,2) → counters restart. No `valid_o` until the new row 2, col 2, whose window is built only from post-`sof_i` pixels.
- Two back-to-back frames, with frame 2 pixels = 12'h1RC → frame 2 windows contain only 12'h1xx values; 4 `valid_o` pulses and 1 `frame_done_o` per frame.
- `reset` pulsed at pixel (2,3) → `valid_o` low next cycle; the next accepted pixel is treated as (0,0); no `valid_o` until 11 further beats.
